// File: rtl/shift_writeback.sv
// +-----------------------------------------------------------------------------+
// | shift_writeback : bit-serial shift stage feeding the register file write    |
// | port (one bit per cycle, start/busy/done handshake).                        |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module shift_writeback #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         Start,
  input  logic         ShiftRight,
  input  logic         Arith,
  input  logic         Quad,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] Amount,
  input  logic [D-1:0] DestReg,
  output logic         Busy,
  output logic         Done,
  output logic         RegWrite,
  output logic [D-1:0] writeReg,
  output logic [W-1:0] writeValue
);

  localparam int          c_CW      = $clog2(W) + 1;
  localparam logic [1:0]  c_S_IDLE  = 2'd0;
  localparam logic [1:0]  c_S_SHIFT = 2'd1;
  localparam logic [1:0]  c_S_WRITE = 2'd2;
  localparam logic [D-1:0]    c_ZERO_REG = '1;
  localparam logic [W-1:0]    c_W_VAL    = W'(W);
  localparam logic [c_CW-1:0] c_CNT_QUAD = c_CW'(4);
  localparam logic [c_CW-1:0] c_CNT_SAT  = c_CW'(W);

  logic [1:0]      r_state;
  logic [1:0]      w_nextState;
  logic [W-1:0]    r_value;
  logic [W-1:0]    r_heldValue;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_loadCount;
  logic [D-1:0]    r_dest;
  logic            r_right;
  logic            r_arith;
  logic [W-1:0]    w_shifted;

  // Quad overrides the amount; anything at or above W saturates to W.
  always_comb begin
    w_loadCount = Amount[c_CW-1:0];
    if (Quad) begin
      w_loadCount = c_CNT_QUAD;
    end else if (Amount >= c_W_VAL) begin
      w_loadCount = c_CNT_SAT;
    end
  end

  always_comb begin
    if (r_right) begin
      w_shifted = {r_arith & r_value[W-1], r_value[W-1:1]};
    end else begin
      w_shifted = {r_value[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (Start) begin
          w_nextState = (w_loadCount != '0) ? c_S_SHIFT : c_S_WRITE;
        end
      end
      c_S_SHIFT: begin
        if (r_count == c_CW'(1)) begin
          w_nextState = c_S_WRITE;
        end
      end
      c_S_WRITE: w_nextState = c_S_IDLE;
      default:   w_nextState = c_S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_value     <= '0;
      r_heldValue <= '0;
      r_count     <= '0;
      r_dest      <= '0;
      r_right     <= 1'b0;
      r_arith     <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (Start) begin
            r_value <= OperandA;
            r_count <= w_loadCount;
            r_dest  <= DestReg;
            r_right <= ShiftRight;
            r_arith <= Arith;
          end
        end
        c_S_SHIFT: begin
          r_value <= w_shifted;
          r_count <= r_count - c_CW'(1);
        end
        c_S_WRITE: r_heldValue <= r_value;
        default: ;
      endcase
    end
  end

  // Outputs decode purely from flops; writeValue holds the last result outside WRITE.
  always_comb begin
    Busy       = (r_state != c_S_IDLE);
    Done       = (r_state == c_S_WRITE);
    RegWrite   = (r_state == c_S_WRITE) && (r_dest != c_ZERO_REG);
    writeReg   = (r_state == c_S_WRITE) ? r_dest : '0;
    writeValue = (r_state == c_S_WRITE) ? r_value : r_heldValue;
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_writeback.sv
// +-----------------------------------------------------------------------------+
// | tb_shift_writeback : randomized self-checking bench for shift_writeback.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_writeback;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         Start = 1'b0;
  logic         ShiftRight = 1'b0;
  logic         Arith = 1'b0;
  logic         Quad = 1'b0;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] Amount = '0;
  logic [D-1:0] DestReg = '0;
  logic         Busy;
  logic         Done;
  logic         RegWrite;
  logic [D-1:0] writeReg;
  logic [W-1:0] writeValue;

  int nTests = 0;
  int nFail  = 0;

  shift_writeback #(.W(W), .D(D)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Start      (Start),
    .ShiftRight (ShiftRight),
    .Arith      (Arith),
    .Quad       (Quad),
    .OperandA   (OperandA),
    .Amount     (Amount),
    .DestReg    (DestReg),
    .Busy       (Busy),
    .Done       (Done),
    .RegWrite   (RegWrite),
    .writeReg   (writeReg),
    .writeValue (writeValue)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int effCount(input logic quad, input logic [W-1:0] amt);
    if (quad) return 4;
    if (int'(amt) >= W) return W;
    return int'(amt);
  endfunction

  function automatic logic [W-1:0] refShift(input logic [W-1:0] a, input int n,
                                            input logic right, input logic arith);
    int unsigned ua;
    int          sa;
    ua = a;
    sa = $signed(a);
    if (!right) return W'(ua << n);
    if (arith)  return W'(sa >>> n);
    return W'(ua >> n);
  endfunction

  task automatic checkIdleZero(input string tag);
    chk({tag, ".busy"}, Busy, 0);
    chk({tag, ".done"}, Done, 0);
    chk({tag, ".regwr"}, RegWrite, 0);
    chk({tag, ".wreg"}, writeReg, 0);
    chk({tag, ".wval"}, writeValue, 0);
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] amt, input logic [D-1:0] dest,
                       input logic right, input logic arith, input logic quad,
                       input logic pulseStart, input logic holdNext, input string tag);
    int           n;
    logic [W-1:0] exp;
    n   = effCount(quad, amt);
    exp = refShift(a, n, right, arith);
    @(negedge CLK);
    OperandA = a; Amount = amt; DestReg = dest;
    ShiftRight = right; Arith = arith; Quad = quad; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    OperandA = W'($urandom); Amount = W'($urandom); DestReg = D'($urandom);
    ShiftRight = 1'($urandom); Arith = 1'($urandom); Quad = 1'($urandom);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      chk({tag, ".busy"}, Busy, 1);
      if (k < n) begin
        chk({tag, ".done_early"}, Done, 0);
        chk({tag, ".regwr_early"}, RegWrite, 0);
        if (pulseStart) Start = 1'($urandom);
      end else begin
        Start = holdNext;
        chk({tag, ".done"}, Done, 1);
        chk({tag, ".regwr"}, RegWrite, (dest != 4'hF));
        chk({tag, ".wreg"}, writeReg, dest);
        chk({tag, ".wval"}, writeValue, exp);
      end
    end
    @(posedge CLK); #1;
    chk({tag, ".busy_end"}, Busy, 0);
    chk({tag, ".done_end"}, Done, 0);
    chk({tag, ".regwr_end"}, RegWrite, 0);
    chk({tag, ".wreg_end"}, writeReg, 0);
    chk({tag, ".wval_hold"}, writeValue, exp);
  endtask

  initial begin
    // Reset held with Start asserted, then released idle.
    RST_N = 1'b0;
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checkIdleZero("rst_hold");
    end
    @(negedge CLK);
    Start = 1'b0;
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      checkIdleZero("rst_rel");
    end

    runOp(8'h13, 8'd3,   4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lsl3");
    runOp(8'h90, 8'd200, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "asr_sat");
    runOp(8'h90, 8'd200, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lsr_sat");
    runOp(8'hA5, 8'd7,   4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "quad");
    runOp(8'h3C, 8'd0,   4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "zero_amt");
    runOp(8'h81, 8'd2,   4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "zero_reg");
    runOp(8'hC3, 8'd5,   4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "pulse_hold");
    runOp(8'h5A, 8'd8,   4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_hold");

    // Asynchronous reset during the second SHIFT cycle.
    @(negedge CLK);
    OperandA = 8'h5A; Amount = 8'd5; DestReg = 4'd3;
    ShiftRight = 1'b0; Arith = 1'b0; Quad = 1'b0; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    checkIdleZero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checkIdleZero("mid_rst_hold");
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checkIdleZero("mid_rst_rel");
    runOp(8'h6B, 8'd1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] amt;
      amt = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 12)) : W'($urandom);
      runOp(W'($urandom), amt, D'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire
